row_window_buffer: RTL and testbench

//  Generalised row-buffer controller between a layer's writer and the next layer's PE array.

---
 rtl/row_window_buffer.sv | 174 +++++++++++++++++
 tb/tb_row_window_buffer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/row_window_buffer.sv
// rtl/row_window_buffer.sv - ring of K+S row banks presenting a sliding, zero-padded K-row window
// Purpose: buffers rows from a producer layer and exposes a K-row window to the
//    next layer's PE array. The window slides by S rows per advance. Virtual zero
//    rows are inserted above and below the image, and the frame wraps automatically.
// Ports:
//    clk, rst                 clock (rising edge), asynchronous active-high reset
//    wr_valid/wr_ready        write handshake, one channel word per beat
//    wr_data                  channel word of the row being written
//    wr_row                   image row currently being written
//    win_valid, out_row       window readable flag and window index
//    rd_en, rd_row, rd_ch     read request: kernel row within window, channel
//    rd_data, rd_valid        read result, one cycle after rd_en
//    win_advance              PE done with window; slide by S
//    frame_done               one-cycle pulse after the last window retires
module row_window_buffer #(
   parameter int DATA_WIDTH = 8,
   parameter int ROW_LEN    = 14,
   parameter int CH         = 16,
   parameter int ROWS       = 10,
   parameter int K          = 3,
   parameter int S          = 1,
   parameter int PAD        = 1
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   wr_valid,
   output logic                                   wr_ready,
   input  logic [ROW_LEN*DATA_WIDTH-1:0]          wr_data,
   output logic [$clog2(ROWS+1)-1:0]              wr_row,
   output logic                                   win_valid,
   output logic [$clog2((ROWS+2*PAD-K)/S+1)-1:0]  out_row,
   input  logic                                   rd_en,
   input  logic [$clog2(K)-1:0]                   rd_row,
   input  logic [$clog2(CH)-1:0]                  rd_ch,
   output logic [ROW_LEN*DATA_WIDTH-1:0]          rd_data,
   output logic                                   rd_valid,
   input  logic                                   win_advance,
   output logic                                   frame_done
);
   localparam int W        = ROW_LEN*DATA_WIDTH;
   localparam int NBUF     = K + S;
   localparam int OUT_ROWS = (ROWS + 2*PAD - K)/S + 1;
   localparam int WRW      = $clog2(ROWS+1);
   localparam int ORW      = $clog2(OUT_ROWS);
   localparam int RW       = $clog2(ROWS+2*PAD) + 2;
   localparam int BIW      = $clog2(NBUF);
   localparam int BW1      = BIW + 1;
   localparam int CHW      = $clog2(CH);

   localparam logic signed [RW-1:0] TOP0   = RW'(-PAD);
   localparam logic signed [RW-1:0] ROWS_S = RW'(ROWS);
   localparam logic signed [RW-1:0] K_S    = RW'(K);
   localparam logic signed [RW-1:0] S_S    = RW'(S);
   localparam logic signed [RW-1:0] NBUF_S = RW'(NBUF);
   localparam logic [BIW-1:0] TOP_BANK0 = BIW'((NBUF - (PAD % NBUF)) % NBUF);
   localparam logic [BIW-1:0] BANK_LAST = BIW'(NBUF-1);
   localparam logic [BW1-1:0] NBUF_U    = BW1'(NBUF);
   localparam logic [ORW-1:0] OUT_LAST  = ORW'(OUT_ROWS-1);
   localparam logic [WRW-1:0] ROWS_U    = WRW'(ROWS);
   localparam logic [CHW-1:0] CH_LAST   = CHW'(CH-1);

   logic [W-1:0] mem_q [NBUF][CH];

   logic signed [RW-1:0] top_q, top_d;
   logic [BIW-1:0]       top_bank_q, top_bank_d;
   logic [BIW-1:0]       wr_bank_q, wr_bank_d;
   logic [WRW-1:0]       wr_row_q, wr_row_d;
   logic [CHW-1:0]       wr_ch_q, wr_ch_d;
   logic [ORW-1:0]       out_row_q, out_row_d;
   logic                 win_valid_q, win_valid_d;
   logic                 rd_valid_q, frame_done_q;
   logic [W-1:0]         rd_data_q;

   logic signed [RW-1:0] wr_row_s, wr_row_ds, top_k, win_lim, rd_row_s, rd_r;
   logic [BW1-1:0]       tb_sum, rb_sum;
   logic [BIW-1:0]       rd_bank;
   logic                 wr_fire, adv_fire, rd_fire, rd_pad;

   assign wr_row_s = RW'(wr_row_q);
   // Distance check keeps the writer off banks still owned by the current window.
   assign wr_ready = !rst && (wr_row_q < ROWS_U) && ((wr_row_s - top_q) < NBUF_S);
   assign wr_fire  = wr_valid && wr_ready;
   assign adv_fire = win_advance && win_valid_q;
   assign rd_fire  = rd_en && win_valid_q;

   // Bank rings advance by compare-and-subtract; both addends are below NBUF.
   assign tb_sum = BW1'(top_bank_q) + BW1'(S);
   assign rb_sum = BW1'(top_bank_q) + BW1'(rd_row);
   assign rd_bank = (rb_sum >= NBUF_U) ? BIW'(rb_sum - NBUF_U) : BIW'(rb_sum);

   assign rd_row_s = RW'(rd_row);
   assign rd_r     = top_q + rd_row_s;
   assign rd_pad   = (rd_r < 0) || (rd_r >= ROWS_S);

   always_comb begin
      top_d      = top_q;
      top_bank_d = top_bank_q;
      out_row_d  = out_row_q;
      wr_row_d   = wr_row_q;
      wr_ch_d    = wr_ch_q;
      wr_bank_d  = wr_bank_q;
      if (wr_fire) begin
         if (wr_ch_q == CH_LAST) begin
            wr_ch_d   = '0;
            wr_row_d  = wr_row_q + WRW'(1);
            wr_bank_d = (wr_bank_q == BANK_LAST) ? '0 : wr_bank_q + BIW'(1);
         end else begin
            wr_ch_d = wr_ch_q + CHW'(1);
         end
      end
      if (adv_fire) begin
         if (out_row_q == OUT_LAST) begin
            // Frame wrap overrides any same-cycle write bookkeeping.
            top_d      = TOP0;
            top_bank_d = TOP_BANK0;
            out_row_d  = '0;
            wr_row_d   = '0;
            wr_ch_d    = '0;
            wr_bank_d  = '0;
         end else begin
            top_d      = top_q + S_S;
            top_bank_d = (tb_sum >= NBUF_U) ? BIW'(tb_sum - NBUF_U) : BIW'(tb_sum);
            out_row_d  = out_row_q + ORW'(1);
         end
      end
      // Evaluated on next-state counters so the flag rises right after the last
      // needed word; forced low for one cycle after an advance.
      wr_row_ds   = RW'(wr_row_d);
      top_k       = top_d + K_S;
      win_lim     = (top_k < ROWS_S) ? top_k : ROWS_S;
      win_valid_d = !adv_fire && (wr_row_ds >= win_lim);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         top_q        <= TOP0;
         top_bank_q   <= TOP_BANK0;
         wr_bank_q    <= '0;
         wr_row_q     <= '0;
         wr_ch_q      <= '0;
         out_row_q    <= '0;
         win_valid_q  <= 1'b0;
         rd_valid_q   <= 1'b0;
         rd_data_q    <= '0;
         frame_done_q <= 1'b0;
      end else begin
         top_q        <= top_d;
         top_bank_q   <= top_bank_d;
         wr_bank_q    <= wr_bank_d;
         wr_row_q     <= wr_row_d;
         wr_ch_q      <= wr_ch_d;
         out_row_q    <= out_row_d;
         win_valid_q  <= win_valid_d;
         rd_valid_q   <= rd_fire;
         frame_done_q <= adv_fire && (out_row_q == OUT_LAST);
         if (rd_fire) begin
            rd_data_q <= rd_pad ? '0 : mem_q[rd_bank][rd_ch];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem_q[wr_bank_q][wr_ch_q] <= wr_data;
      end
   end

   assign wr_row     = wr_row_q;
   assign win_valid  = win_valid_q;
   assign out_row    = out_row_q;
   assign rd_data    = rd_data_q;
   assign rd_valid   = rd_valid_q;
   assign frame_done = frame_done_q;
endmodule

// File: tb/tb_row_window_buffer.sv
// tb/tb_row_window_buffer.sv - directed checks of row_window_buffer for stride 1 and stride 2
module tb_row_window_buffer;
   localparam int W = 112;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, sel;
   logic         wr_valid, rd_en, win_advance;
   logic [W-1:0] wr_data;
   logic [1:0]   rd_row, rd_ch;

   logic         a_wr_ready, a_win_valid, a_rd_valid, a_frame_done;
   logic [3:0]   a_wr_row, a_out_row;
   logic [W-1:0] a_rd_data;
   logic         b_wr_ready, b_win_valid, b_rd_valid, b_frame_done;
   logic [3:0]   b_wr_row;
   logic [2:0]   b_out_row;
   logic [W-1:0] b_rd_data;

   logic         wr_ready, win_valid, rd_valid, frame_done;
   logic [3:0]   wr_row, out_row;
   logic [W-1:0] rd_data;

   row_window_buffer #(.DATA_WIDTH(8), .ROW_LEN(14), .CH(4), .ROWS(10), .K(3), .S(1), .PAD(1)) dut_a (
      .clk(clk), .rst(rst),
      .wr_valid(wr_valid && !sel), .wr_ready(a_wr_ready), .wr_data(wr_data), .wr_row(a_wr_row),
      .win_valid(a_win_valid), .out_row(a_out_row),
      .rd_en(rd_en && !sel), .rd_row(rd_row), .rd_ch(rd_ch), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
      .win_advance(win_advance && !sel), .frame_done(a_frame_done));

   row_window_buffer #(.DATA_WIDTH(8), .ROW_LEN(14), .CH(4), .ROWS(10), .K(3), .S(2), .PAD(1)) dut_b (
      .clk(clk), .rst(rst),
      .wr_valid(wr_valid && sel), .wr_ready(b_wr_ready), .wr_data(wr_data), .wr_row(b_wr_row),
      .win_valid(b_win_valid), .out_row(b_out_row),
      .rd_en(rd_en && sel), .rd_row(rd_row), .rd_ch(rd_ch), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
      .win_advance(win_advance && sel), .frame_done(b_frame_done));

   assign wr_ready   = sel ? b_wr_ready   : a_wr_ready;
   assign win_valid  = sel ? b_win_valid  : a_win_valid;
   assign rd_valid   = sel ? b_rd_valid   : a_rd_valid;
   assign frame_done = sel ? b_frame_done : a_frame_done;
   assign wr_row     = sel ? b_wr_row     : a_wr_row;
   assign out_row    = sel ? {1'b0, b_out_row} : a_out_row;
   assign rd_data    = sel ? b_rd_data    : a_rd_data;

   int checks, failures;
   int frame, wrow, wch;

   typedef struct {
      int           row;
      int           ch;
      logic [W-1:0] exp;
      string        nm;
   } rvec_t;
   rvec_t t2 [6];

   function automatic logic [W-1:0] pix(input int f, input int r, input int c);
      return W'(f*256 + r*16 + c);
   endfunction

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // One handshake; caller has already seen wr_ready high.
   task automatic put_word;
      wr_valid = 1'b1;
      wr_data  = pix(frame, wrow, wch);
      tick;
      wr_valid = 1'b0;
      if (wch == 3) begin
         wch = 0;
         wrow++;
      end else begin
         wch++;
      end
   endtask

   task automatic write_words(input int n);
      for (int i = 0; i < n; i++) begin
         int g = 0;
         while (!wr_ready && g < 50) begin
            tick;
            g++;
         end
         if (!wr_ready) begin
            chk("wr_ready_timeout", W'(wr_ready), W'(1));
            return;
         end
         put_word;
      end
   endtask

   task automatic fill;
      int g = 0;
      while (!win_valid && g < 200) begin
         if (wr_ready && wrow < 10) put_word;
         else tick;
         g++;
      end
      chk("fill_win_valid", W'(win_valid), W'(1));
   endtask

   task automatic rd(input int r, input int c, input logic [W-1:0] exp, input string nm);
      rd_en  = 1'b1;
      rd_row = 2'(r);
      rd_ch  = 2'(c);
      tick;
      rd_en = 1'b0;
      chk({nm, "_valid"}, W'(rd_valid), W'(1));
      chk(nm, rd_data, exp);
   endtask

   task automatic advance;
      win_advance = 1'b1;
      tick;
      win_advance = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      checks = 0; failures = 0;
      sel = 1'b0; rst = 1'b1;
      wr_valid = 1'b0; rd_en = 1'b0; win_advance = 1'b0;
      wr_data = '0; rd_row = '0; rd_ch = '0;
      frame = 3; wrow = 0; wch = 0;

      t2[0] = '{0, 0, '0,           "w0_pad_top_c0"};
      t2[1] = '{0, 3, '0,           "w0_pad_top_c3"};
      t2[2] = '{1, 3, pix(0, 0, 3), "w0_row0_c3"};
      t2[3] = '{1, 2, pix(0, 0, 2), "w0_row0_c2"};
      t2[4] = '{2, 1, pix(0, 1, 1), "w0_row1_c1"};
      t2[5] = '{2, 3, pix(0, 1, 3), "w0_row1_c3"};

      tick; tick;
      chk("rst_wr_ready", W'(wr_ready), W'(0));
      chk("rst_win_valid", W'(win_valid), W'(0));
      rst = 1'b0;
      tick;

      // Build up state, then reset mid-stream.
      write_words(8);
      rd(2, 3, pix(3, 1, 3), "pre_rst_rd");
      rst = 1'b1;
      #1;
      chk("mid_rst_wr_ready", W'(wr_ready), W'(0));
      chk("mid_rst_win_valid", W'(win_valid), W'(0));
      chk("mid_rst_rd_valid", W'(rd_valid), W'(0));
      chk("mid_rst_rd_data", rd_data, W'(0));
      chk("mid_rst_frame_done", W'(frame_done), W'(0));
      chk("mid_rst_wr_row", W'(wr_row), W'(0));
      chk("mid_rst_out_row", W'(out_row), W'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("post_rst_wr_ready", W'(wr_ready), W'(1));
      chk("post_rst_wr_row", W'(wr_row), W'(0));
      chk("post_rst_out_row", W'(out_row), W'(0));
      frame = 0; wrow = 0; wch = 0;

      // First window needs rows 0 and 1 (top is the padding row).
      write_words(7);
      chk("w0_not_ready_after_7", W'(win_valid), W'(0));
      write_words(1);
      chk("w0_valid_after_8", W'(win_valid), W'(1));
      for (int i = 0; i < 6; i++) rd(t2[i].row, t2[i].ch, t2[i].exp, t2[i].nm);

      // Writer fills the ring and stalls.
      write_words(4);
      wr_valid = 1'b1;
      wr_data  = '1;
      tick; tick;
      chk("stall_wr_ready", W'(wr_ready), W'(0));
      chk("stall_wr_row", W'(wr_row), W'(3));
      chk("stall_win_valid", W'(win_valid), W'(1));
      wr_valid = 1'b0;

      // Advance with same-cycle read: read sees the old (padded) window.
      win_advance = 1'b1; rd_en = 1'b1; rd_row = 2'd0; rd_ch = 2'd3;
      tick;
      win_advance = 1'b0; rd_en = 1'b0;
      chk("adv_out_row", W'(out_row), W'(1));
      chk("adv_wr_ready", W'(wr_ready), W'(1));
      chk("adv_win_drop", W'(win_valid), W'(0));
      chk("adv_rd_valid", W'(rd_valid), W'(1));
      chk("adv_rd_old_window", rd_data, W'(0));

      // Read and advance while the window is not valid are ignored.
      rd_en = 1'b1; win_advance = 1'b1;
      tick;
      rd_en = 1'b0; win_advance = 1'b0;
      chk("ign_rd_valid", W'(rd_valid), W'(0));
      chk("ign_out_row", W'(out_row), W'(1));
      chk("w1_revalid", W'(win_valid), W'(1));
      rd(0, 3, pix(0, 0, 3), "w1_row0_c3");

      // Remaining windows of the frame.
      for (int w = 1; w <= 9; w++) begin
         fill;
         chk($sformatf("s1_out_row_%0d", w), W'(out_row), W'(w));
         rd(1, w % 4, pix(0, w, w % 4), $sformatf("s1_win%0d_mid", w));
         if (w < 9) advance;
      end
      rd(0, 1, pix(0, 8, 1), "w9_row8");
      rd(1, 2, pix(0, 9, 2), "w9_row9");
      rd(2, 0, '0, "w9_pad_bottom");
      advance;
      chk("fd_pulse", W'(frame_done), W'(1));
      chk("fd_out_row", W'(out_row), W'(0));
      chk("fd_wr_row", W'(wr_row), W'(0));
      chk("fd_win_valid", W'(win_valid), W'(0));
      tick;
      chk("fd_one_cycle", W'(frame_done), W'(0));

      // Second frame repeats the first.
      frame = 1; wrow = 0; wch = 0;
      write_words(7);
      chk("f2_not_ready_after_7", W'(win_valid), W'(0));
      write_words(1);
      chk("f2_valid_after_8", W'(win_valid), W'(1));
      rd(2, 3, pix(1, 1, 3), "f2_row1_c3");
      rd(0, 3, '0, "f2_pad_top");
      chk("f2_out_row", W'(out_row), W'(0));

      // Stride 2 instance: NBUF=5, OUT_ROWS=5.
      sel = 1'b1;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      tick;
      frame = 2; wrow = 0; wch = 0;
      for (int w = 0; w < 5; w++) begin
         int top;
         top = -1 + 2*w;
         fill;
         chk($sformatf("s2_out_row_%0d", w), W'(out_row), W'(w));
         if (w == 0) begin
            int g = 0;
            while (wr_ready && g < 50) begin
               put_word;
               g++;
            end
            chk("s2_stall_wr_row", W'(wr_row), W'(4));
            chk("s2_stall_wr_ready", W'(wr_ready), W'(0));
         end
         rd(0, 1, (top < 0) ? W'(0) : pix(2, top, 1), $sformatf("s2_win%0d_r0", w));
         rd(2, 2, pix(2, top + 2, 2), $sformatf("s2_win%0d_r2", w));
         advance;
         chk($sformatf("s2_frame_done_%0d", w), W'(frame_done), (w == 4) ? W'(1) : W'(0));
      end
      chk("s2_wrap_out_row", W'(out_row), W'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
